// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_seq_pkg;

  localparam int unsigned MUL_N     = 16;
  localparam int unsigned MUL_CNT_W = $clog2(MUL_N);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS_A,
    ST_ABS_B,
    ST_RUN,
    ST_NEG_LO,
    ST_NEG_HI,
    ST_DONE
  } mul_state_t;

endpackage

// File: rtl/bit16_Adder.sv
// N-bit ripple adder with carry-out; the single arithmetic resource shared by the controller.
module bit16_Adder #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic [N:0] w_sum;

  assign w_sum = {1'b0, A} + {1'b0, B};
  assign S     = w_sum[N-1:0];
  assign Cout  = w_sum[N];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential N x N -> 2N multiplier: sign-magnitude conversion, N shift-add steps and
// a two-step 2N-bit negate, all through one shared adder. Fixed latency in both modes.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned N = MUL_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int unsigned     CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  mul_state_t       r_state;
  mul_state_t       w_next;

  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [N-1:0]     r_acc_hi;
  logic [N-1:0]     r_p_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sm;
  logic             r_neg;
  logic             r_c_lo;

  logic [N-1:0]     w_add_a;
  logic [N-1:0]     w_add_b;
  logic [N-1:0]     w_sum;
  logic             w_cout;

  bit16_Adder #(.N(N)) u_adder (
    .A    (w_add_a),
    .B    (w_add_b),
    .S    (w_sum),
    .Cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Adder operands are muxed by state; negation is ~x + 1 through the shared adder.
  always_comb begin
    w_next  = r_state;
    w_add_a = '0;
    w_add_b = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) w_next = ST_ABS_A;
      end
      ST_ABS_A: begin
        w_add_a = ~r_a;
        w_add_b = N'(1);
        w_next  = abort ? ST_IDLE : ST_ABS_B;
      end
      ST_ABS_B: begin
        w_add_a = ~r_b;
        w_add_b = N'(1);
        w_next  = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        w_add_a = r_acc_hi;
        w_add_b = r_p_lo[0] ? r_a : '0;
        if (abort)                 w_next = ST_IDLE;
        else if (r_cnt == CNT_LAST) w_next = ST_NEG_LO;
      end
      ST_NEG_LO: begin
        if (r_neg) begin
          w_add_a = ~r_p_lo;
          w_add_b = N'(1);
        end
        w_next = abort ? ST_IDLE : ST_NEG_HI;
      end
      ST_NEG_HI: begin
        if (r_neg) begin
          w_add_a = ~r_acc_hi;
          w_add_b = N'(r_c_lo);
        end
        w_next = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_p_lo   <= '0;
      r_cnt    <= '0;
      r_sm     <= 1'b0;
      r_neg    <= 1'b0;
      r_c_lo   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_sm     <= signed_mode;
            r_neg    <= signed_mode & (a[N-1] ^ b[N-1]);
            r_acc_hi <= '0;
            r_cnt    <= '0;
          end
        end
        ST_ABS_A: begin
          if (r_sm && r_a[N-1]) r_a <= w_sum;
        end
        ST_ABS_B: begin
          r_p_lo <= (r_sm && r_b[N-1]) ? w_sum : r_b;
        end
        ST_RUN: begin
          {r_acc_hi, r_p_lo} <= {w_cout, w_sum, r_p_lo[N-1:1]};
          r_cnt              <= r_cnt + CNT_W'(1);
        end
        ST_NEG_LO: begin
          if (r_neg) begin
            r_p_lo <= w_sum;
            r_c_lo <= w_cout;
          end
        end
        ST_NEG_HI: begin
          if (r_neg) r_acc_hi <= w_sum;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign product   = {r_acc_hi, r_p_lo};

endmodule
